mush_sprite_ctrl: RTL and testbench

- Object controller and pixel address generator for the mushroom power-up sprite; sits directly upstream of the mushroom sprite ROM.
- Tracks mushroom position and motion (emerge from block, then walk and bounce) once per frame.
- For every VGA pixel, computes the 9-bit ROM read address and registers the returned 12-bit colour.
- Emits mush_on (opaque pixel present) and mush_color to the colour mapper, with transparency keying.

---
 rtl/mush_pkg.sv | 23 ++
 rtl/mush_addr_pipe.sv | 91 +++++++++
 rtl/mush_sprite_ctrl.sv | 155 +++++++++++++++
 tb/tb_mush_sprite_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mush_pkg.sv
// Shared types and constants for the mushroom power-up sprite controller.
//   - mush_state_e : object FSM states (idle, rising out of block, walking)
//   - mush_dir_e   : horizontal walk direction
//   - screen size and the ROM transparency key colour
package mush_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRise = 2'd1,
    StWalk = 2'd2
  } mush_state_e;

  typedef enum logic {
    DirRight = 1'b0,
    DirLeft  = 1'b1
  } mush_dir_e;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam logic [11:0] KEY_COLOR_DEF = 12'h808;

endpackage

// File: rtl/mush_addr_pipe.sv
// Two-stage pixel pipeline for the mushroom sprite.
//   Stage 1: hit test of the current VGA pixel against the sprite box and
//            ROM address generation (row*SPR_W + col).
//   Stage 2: registers the ROM colour and applies transparency keying.
// Build option: MUSH_FLIP_EN mirrors the column while walking left.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   active_i, rising_i     object present / still emerging from the block
//   mirror_i               walking left (used only with MUSH_FLIP_EN)
//   pos_x_i, pos_y_i       sprite top-left corner
//   clip_y_i               block top line; rows at or below it are hidden while rising
//   draw_x_i, draw_y_i     current pixel from the VGA controller
//   rom_color_i            combinational ROM data for rom_addr_o
//   rom_addr_o             registered ROM address
//   pix_on_o, pix_color_o  opaque-pixel flag and colour, 2 cycles after draw_x/draw_y
module mush_addr_pipe
  import mush_pkg::*;
#(
  parameter int unsigned SPR_W     = 20,
  parameter int unsigned SPR_H     = 22,
  parameter logic [11:0] KEY_COLOR = KEY_COLOR_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        active_i,
  input  logic        rising_i,
  input  logic        mirror_i,
  input  logic [9:0]  pos_x_i,
  input  logic [9:0]  pos_y_i,
  input  logic [9:0]  clip_y_i,
  input  logic [9:0]  draw_x_i,
  input  logic [9:0]  draw_y_i,
  input  logic [11:0] rom_color_i,
  output logic [8:0]  rom_addr_o,
  output logic        pix_on_o,
  output logic [11:0] pix_color_o
);

  logic [9:0]  col, row;
  logic [8:0]  col_sel;
  logic [8:0]  addr_d, addr_q;
  logic        hit_d, hit_q;
  logic        opaque;
  logic        on_q;
  logic [11:0] color_q;

  assign col = draw_x_i - pos_x_i;
  assign row = draw_y_i - pos_y_i;

  always_comb begin
    hit_d = active_i && (draw_x_i >= pos_x_i) && (col < 10'(SPR_W)) &&
            (draw_y_i >= pos_y_i) && (row < 10'(SPR_H));
    // While emerging, the part still inside the block stays hidden.
    if (rising_i && (draw_y_i >= clip_y_i)) begin
      hit_d = 1'b0;
    end
    col_sel = col[8:0];
`ifdef MUSH_FLIP_EN
    if (mirror_i) begin
      col_sel = 9'(SPR_W - 1) - col[8:0];
    end
`endif
    addr_d = hit_d ? (9'(row[8:0] * 9'(SPR_W)) + col_sel) : 9'd0;
  end

`ifndef MUSH_FLIP_EN
  logic unused_mirror;
  assign unused_mirror = mirror_i;
`endif

  assign opaque = hit_q && (rom_color_i != KEY_COLOR);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      hit_q   <= 1'b0;
      on_q    <= 1'b0;
      color_q <= '0;
    end else begin
      addr_q  <= addr_d;
      hit_q   <= hit_d;
      on_q    <= opaque;
      color_q <= opaque ? rom_color_i : 12'h000;
    end
  end

  assign rom_addr_o  = addr_q;
  assign pix_on_o    = on_q;
  assign pix_color_o = color_q;

endmodule

// File: rtl/mush_sprite_ctrl.sv
// Mushroom power-up object controller and sprite ROM address generator.
// The object emerges upward from a block after spawn, then walks and bounces
// between X_MIN and X_MAX; motion advances only on frame_tick so each frame is
// drawn from a stable position. Pixel hit/address/keying lives in mush_addr_pipe.
// Build option: define MUSH_FLIP_EN to mirror the sprite while walking left.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   frame_tick            one pulse per frame
//   spawn, spawn_x/y      start emerging at (spawn_x, spawn_y) when idle
//   collect               remove the mushroom (any non-idle state)
//   DrawX, DrawY          current VGA pixel
//   sprite_color          ROM data for read_address
//   read_address          ROM address row*SPR_W + col
//   mush_on, mush_color   opaque pixel and its colour, 2 cycles after DrawX/DrawY
//   mush_x, mush_y        sprite top-left corner
//   active                object is present
module mush_sprite_ctrl
  import mush_pkg::*;
#(
  parameter int unsigned SPR_W     = 20,
  parameter int unsigned SPR_H     = 22,
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = SCREEN_W - 1,
  parameter int unsigned SPEED     = 1,
  parameter logic [11:0] KEY_COLOR = KEY_COLOR_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        spawn,
  input  logic [9:0]  spawn_x,
  input  logic [9:0]  spawn_y,
  input  logic        collect,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [11:0] sprite_color,
  output logic [8:0]  read_address,
  output logic        mush_on,
  output logic [11:0] mush_color,
  output logic [9:0]  mush_x,
  output logic [9:0]  mush_y,
  output logic        active
);

  localparam int unsigned RiseW = $clog2(SPR_H + 1);
  localparam logic [RiseW-1:0] RiseLast = RiseW'(SPR_H - 1);

  mush_state_e      state_q, state_d;
  mush_dir_e        dir_q, dir_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [9:0]       block_y_q, block_y_d;
  logic [RiseW-1:0] rise_q, rise_d;
  logic [10:0]      right_next;

  // Right edge after a step, one bit wider so it cannot wrap.
  assign right_next = {1'b0, x_q} + 11'(SPR_W - 1 + SPEED);

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    x_d       = x_q;
    y_d       = y_q;
    block_y_d = block_y_q;
    rise_d    = rise_q;
    unique case (state_q)
      StIdle: begin
        if (spawn) begin
          x_d       = spawn_x;
          y_d       = spawn_y;
          block_y_d = spawn_y;
          rise_d    = '0;
          dir_d     = DirRight;
          state_d   = StRise;
        end
      end
      StRise: begin
        if (collect) begin
          state_d = StIdle;
        end else if (frame_tick) begin
          rise_d = rise_q + 1'b1;
          y_d    = y_q - 10'd1;
          if (rise_q == RiseLast) begin
            state_d = StWalk;
          end
        end
      end
      StWalk: begin
        if (collect) begin
          state_d = StIdle;
        end else if (frame_tick) begin
          if (dir_q == DirRight) begin
            if (right_next > 11'(X_MAX)) begin
              x_d   = 10'(X_MAX - SPR_W + 1);
              dir_d = DirLeft;
            end else begin
              x_d = x_q + 10'(SPEED);
            end
          end else begin
            if (x_q < 10'(X_MIN + SPEED)) begin
              x_d   = 10'(X_MIN);
              dir_d = DirRight;
            end else begin
              x_d = x_q - 10'(SPEED);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      dir_q     <= DirRight;
      x_q       <= '0;
      y_q       <= '0;
      block_y_q <= '0;
      rise_q    <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      x_q       <= x_d;
      y_q       <= y_d;
      block_y_q <= block_y_d;
      rise_q    <= rise_d;
    end
  end

  assign mush_x = x_q;
  assign mush_y = y_q;
  assign active = (state_q != StIdle);

  mush_addr_pipe #(
    .SPR_W     (SPR_W),
    .SPR_H     (SPR_H),
    .KEY_COLOR (KEY_COLOR)
  ) u_addr_pipe (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .active_i    (state_q != StIdle),
    .rising_i    (state_q == StRise),
    .mirror_i    (dir_q == DirLeft),
    .pos_x_i     (x_q),
    .pos_y_i     (y_q),
    .clip_y_i    (block_y_q),
    .draw_x_i    (DrawX),
    .draw_y_i    (DrawY),
    .rom_color_i (sprite_color),
    .rom_addr_o  (read_address),
    .pix_on_o    (mush_on),
    .pix_color_o (mush_color)
  );

endmodule

// File: tb/tb_mush_sprite_ctrl.sv
// Self-checking bench for mush_sprite_ctrl: directed sequences, a table of
// pixel vectors with forced ROM colours, and a randomized run against a
// behavioural model of the mushroom motion and pixel rules.
module tb_mush_sprite_ctrl;

  localparam int SPR_W = 20;
  localparam int SPR_H = 22;
  localparam int X_MIN = 0;
  localparam int X_MAX = 639;
  localparam int SPEED = 1;
  localparam logic [11:0] KEY = 12'h808;

  logic        Clk = 1'b0;
  logic        Reset, frame_tick, spawn, collect;
  logic [9:0]  spawn_x, spawn_y, DrawX, DrawY;
  logic [11:0] sprite_color;
  logic [8:0]  read_address;
  logic        mush_on;
  logic [11:0] mush_color;
  logic [9:0]  mush_x, mush_y;
  logic        active;

  logic        rom_force_en = 1'b0;
  logic [11:0] rom_force = 12'h000;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  function automatic logic [11:0] rom_fn(input logic [8:0] a);
    if (int'(a) % 5 == 2) return KEY;
    return {3'b101, a};
  endfunction

  assign sprite_color = rom_force_en ? rom_force : rom_fn(read_address);

  mush_sprite_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .spawn        (spawn),
    .spawn_x      (spawn_x),
    .spawn_y      (spawn_y),
    .collect      (collect),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .sprite_color (sprite_color),
    .read_address (read_address),
    .mush_on      (mush_on),
    .mush_color   (mush_color),
    .mush_x       (mush_x),
    .mush_y       (mush_y),
    .active       (active)
  );

  // Behavioural model: object present, emerging flag, position, direction.
  bit m_on = 0, m_rising = 0, m_left = 0;
  int m_x = 0, m_y = 0, m_rise = 0, m_sy = 0;
  // Expected pipeline contents: s1 = stage 1 (address), s2 = feeding stage 2.
  bit s1_hit = 0, s2_hit = 0;
  int s1_addr = 0, s2_addr = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic pix(input int dx, input int dy, output bit hit, output int addr);
    int col, row;
    col = dx - m_x;
    row = dy - m_y;
    hit = m_on && col >= 0 && col < SPR_W && row >= 0 && row < SPR_H &&
          !(m_rising && dy >= m_sy);
`ifdef MUSH_FLIP_EN
    if (m_left) col = SPR_W - 1 - col;
`endif
    addr = hit ? row * SPR_W + col : 0;
  endtask

  task automatic model_edge(input bit rst, input bit tick, input bit sp, input bit col,
                            input int sx, input int sy);
    if (rst) begin
      m_on = 0; m_rising = 0; m_left = 0; m_x = 0; m_y = 0; m_rise = 0; m_sy = 0;
    end else if (!m_on) begin
      if (sp) begin
        m_on = 1; m_rising = 1; m_left = 0; m_x = sx; m_y = sy; m_sy = sy; m_rise = 0;
      end
    end else if (col) begin
      m_on = 0;
    end else if (tick) begin
      if (m_rising) begin
        m_rise++;
        m_y--;
        if (m_rise == SPR_H) m_rising = 0;
      end else if (!m_left) begin
        if (m_x + SPR_W - 1 + SPEED > X_MAX) begin
          m_x = X_MAX - SPR_W + 1;
          m_left = 1;
        end else m_x += SPEED;
      end else begin
        if (m_x < X_MIN + SPEED) begin
          m_x = X_MIN;
          m_left = 0;
        end else m_x -= SPEED;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, and advance model + expected pipeline.
  task automatic cycle(input bit rst, input bit tick, input bit sp, input bit col,
                       input int sx, input int sy, input int dx, input int dy);
    bit h;
    int a;
    Reset      = rst;
    frame_tick = tick;
    spawn      = sp;
    collect    = col;
    spawn_x    = 10'(sx);
    spawn_y    = 10'(sy);
    DrawX      = 10'(dx);
    DrawY      = 10'(dy);
    pix(dx & 1023, dy & 1023, h, a);
    @(posedge Clk);
    #1;
    model_edge(rst, tick, sp, col, sx, sy);
    s2_hit = s1_hit; s2_addr = s1_addr;
    s1_hit = h;      s1_addr = a;
    if (rst) begin
      s1_hit = 0; s1_addr = 0; s2_hit = 0; s2_addr = 0;
    end
  endtask

  task automatic idle_cycle(input bit tick);
    cycle(1'b0, tick, 1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic check_all();
    bit exp_on;
    int exp_col;
    exp_on  = s2_hit && (rom_fn(9'(s2_addr)) != KEY);
    exp_col = exp_on ? int'(rom_fn(9'(s2_addr))) : 0;
    check("rnd_mush_x", int'(mush_x), m_x);
    check("rnd_mush_y", int'(mush_y), m_y);
    check("rnd_active", int'(active), int'(m_on));
    check("rnd_read_address", int'(read_address), s1_addr);
    check("rnd_mush_on", int'(mush_on), int'(exp_on));
    check("rnd_mush_color", int'(mush_color), exp_col);
  endtask

  typedef struct {
    int          dx;
    int          dy;
    logic [11:0] color;
    int          addr;
    bit          on;
    logic [11:0] ocolor;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Sprite at (100,195), block top 200, still rising.
    vecs[0] = '{105, 196, 12'hF30, 25, 1'b1, 12'hF30};
    vecs[1] = '{105, 196, 12'h808, 25, 1'b0, 12'h000};
    vecs[2] = '{100, 195, 12'hF30, 0,  1'b1, 12'hF30};
    vecs[3] = '{119, 199, 12'h123, 99, 1'b1, 12'h123};
    vecs[4] = '{119, 200, 12'hF30, 0,  1'b0, 12'h000};  // clipped by block
    vecs[5] = '{120, 196, 12'hF30, 0,  1'b0, 12'h000};  // col == SPR_W
    vecs[6] = '{99,  196, 12'hF30, 0,  1'b0, 12'h000};  // left of sprite
    vecs[7] = '{100, 194, 12'hF30, 0,  1'b0, 12'h000};  // above sprite

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);

    // Idle after reset: nothing drawn anywhere.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, i * 100, i * 80);
      check("reset_read_address", int'(read_address), 0);
      check("reset_mush_on", int'(mush_on), 0);
      check("reset_active", int'(active), 0);
    end
    check("reset_mush_x", int'(mush_x), 0);
    check("reset_mush_color", int'(mush_color), 0);

    // Spawn and rise five frames.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 100, 200, 0, 0);
    check("spawn_x", int'(mush_x), 100);
    check("spawn_y", int'(mush_y), 200);
    check("spawn_active", int'(active), 1);
    for (int t = 1; t <= 5; t++) begin
      idle_cycle(1'b1);
      check("rise_y", int'(mush_y), 200 - t);
    end

    // Pixel table with forced ROM colours.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, vecs[i].dx, vecs[i].dy);
      check("vec_read_address", int'(read_address), vecs[i].addr);
      rom_force    = vecs[i].color;
      rom_force_en = 1'b1;
      idle_cycle(1'b0);
      rom_force_en = 1'b0;
      check("vec_mush_on", int'(mush_on), int'(vecs[i].on));
      check("vec_mush_color", int'(mush_color), int'(vecs[i].ocolor));
    end

    for (int t = 6; t <= 22; t++) begin
      idle_cycle(1'b1);
      check("rise_y", int'(mush_y), 200 - t);
    end
    idle_cycle(1'b1);
    check("walk_first_x", int'(mush_x), 101);
    check("walk_first_y", int'(mush_y), 178);

    // Walk to the right wall and bounce.
    for (int k = 0; k < 518; k++) idle_cycle(1'b1);
    check("wall_619", int'(mush_x), 619);
    idle_cycle(1'b1);
    check("wall_620", int'(mush_x), 620);
    idle_cycle(1'b1);
    check("wall_clamp", int'(mush_x), 620);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 620, 178);
`ifdef MUSH_FLIP_EN
    check("flip_addr", int'(read_address), 19);
`else
    check("flip_addr", int'(read_address), 0);
`endif
    idle_cycle(1'b1);
    check("wall_back_619", int'(mush_x), 619);
    idle_cycle(1'b1);
    check("wall_back_618", int'(mush_x), 618);

    // spawn while walking is ignored; collect beats frame_tick.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 5, 300, 0, 0);
    check("spawn_ignored_x", int'(mush_x), 618);
    check("spawn_ignored_y", int'(mush_y), 178);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
    check("collect_x", int'(mush_x), 618);
    check("collect_active", int'(active), 0);

    // Mid-frame reset flushes the pixel pipeline.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 300, 100, 0, 0);
    for (int t = 0; t < 22; t++) idle_cycle(1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 300, 80);
    check("pre_reset_addr", int'(read_address), 40);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 300, 80);
    check("midreset_addr", int'(read_address), 0);
    check("midreset_on", int'(mush_on), 0);
    check("midreset_active", int'(active), 0);
    check("midreset_x", int'(mush_x), 0);
    idle_cycle(1'b0);
    check("midreset_on_after", int'(mush_on), 0);

    // Randomized run against the model.
    for (int c = 0; c < 4000; c++) begin
      bit rst, tick, sp, col;
      int sx, sy, dx, dy;
      rst  = ($urandom_range(0, 499) == 0);
      tick = ($urandom_range(0, 2) == 0);
      sp   = ($urandom_range(0, 39) == 0);
      col  = ($urandom_range(0, 299) == 0);
      sx   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 620))
                                         : int'($urandom_range(590, 620));
      sy   = int'($urandom_range(22, 479));
      dx   = m_x + int'($urandom_range(0, 27)) - 3;
      dy   = m_y + int'($urandom_range(0, 29)) - 3;
      cycle(rst, tick, sp, col, sx, sy, dx, dy);
      check_all();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
